// File: rtl/sm3_cf_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sm3_cf_arbiter_if
// Purpose  : Bundles the requester-side and sm3_CF-side signals of the
//            shared compression-function arbiter.
// Ports    : req/req_iv/req_blk   - per-requester request and operands
//            gnt/done/err         - per-requester grant, completion, abort
//            hash_out/busy        - last result and activity flag
//            cf_start/cf_iv/cf_blk/cf_hash/cf_end - sm3_CF handshake
// Modports : slave  - the arbiter
//            master - the surrounding environment (requesters + core)
// Revision : 1.0 - initial release
// ============================================================================
interface sm3_cf_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]     req;
    logic [N_REQ*256-1:0] req_iv;
    logic [N_REQ*512-1:0] req_blk;
    logic [N_REQ-1:0]     gnt;
    logic [N_REQ-1:0]     done;
    logic [N_REQ-1:0]     err;
    logic [255:0]         hash_out;
    logic                 busy;
    logic                 cf_start;
    logic [255:0]         cf_iv;
    logic [511:0]         cf_blk;
    logic [255:0]         cf_hash;
    logic                 cf_end;

    modport slave (
        input  req, req_iv, req_blk, cf_hash, cf_end,
        output gnt, done, err, hash_out, busy, cf_start, cf_iv, cf_blk
    );

    modport master (
        output req, req_iv, req_blk, cf_hash, cf_end,
        input  gnt, done, err, hash_out, busy, cf_start, cf_iv, cf_blk
    );
endinterface
`default_nettype wire

// File: rtl/sm3_cf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sm3_cf_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one sm3_CF compression
//            core between N_REQ hash controllers. Grants one requester,
//            latches its chaining value and block, drives the core's
//            start/end handshake and returns the result with a one-cycle
//            done pulse.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous, active-low reset
//            bus   - sm3_cf_arbiter_if.slave (requester + core signals)
// Params   : N_REQ       - number of requesters (2..8)
//            WDOG_CYCLES - watchdog limit in ISSUE cycles
// Macro    : SM3_CF_ARB_WDOG_EN - builds the ISSUE watchdog and err pulses;
//            without it err is tied to 0 and ISSUE waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module sm3_cf_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WDOG_CYCLES = 255
) (
    input  wire             clk,
    input  wire             reset,
    sm3_cf_arbiter_if.slave bus
);

    localparam int c_IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_LAST_INT = N_REQ - 1;

    localparam logic [c_IDX_W:0]   c_N    = N_REQ[c_IDX_W:0];
    localparam logic [c_IDX_W-1:0] c_LAST = c_LAST_INT[c_IDX_W-1:0];
    localparam logic [N_REQ-1:0]   c_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

    generate
        if (N_REQ < 2 || N_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
            $error("sm3_cf_arbiter: N_REQ must be 2..8 and WDOG_CYCLES >= 1");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] r_idx;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic [255:0]       r_hash_out;
    logic               r_busy;
    logic               r_cf_start;
    logic [255:0]       r_cf_iv;
    logic [511:0]       r_cf_blk;

`ifdef SM3_CF_ARB_WDOG_EN
    localparam int c_WDOG_W        = $clog2(WDOG_CYCLES + 1);
    localparam int c_WDOG_LAST_INT = WDOG_CYCLES - 1;
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_LAST_INT[c_WDOG_W-1:0];

    logic [N_REQ-1:0]    r_err;
    logic [c_WDOG_W-1:0] r_wdog_cnt;
`endif

    // ------------------------------------------------------------------------
    // Round-robin winner: candidate k is (ptr + k) mod N_REQ; the lowest k
    // whose request is high wins.
    // ------------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_rot_idx [N_REQ];
    logic [c_IDX_W-1:0] w_win_idx;
    logic [c_IDX_W-1:0] w_ptr_next;
    logic               w_any_req;

    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_rot
            localparam int c_K = k;
            logic [c_IDX_W:0] w_sum;
            assign w_sum        = {1'b0, r_ptr} + c_K[c_IDX_W:0];
            assign w_rot_idx[k] = (w_sum >= c_N) ? c_IDX_W'(w_sum - c_N)
                                                 : c_IDX_W'(w_sum);
        end
    endgenerate

    always_comb begin
        w_win_idx = '0;
        // Descending scan so the smallest offset from ptr is the last write.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req[w_rot_idx[k]]) begin
                w_win_idx = w_rot_idx[k];
            end
        end
    end

    assign w_any_req  = |bus.req;
    assign w_ptr_next = (w_win_idx == c_LAST) ? '0 : w_win_idx + c_IDX_W'(1);

    // ------------------------------------------------------------------------
    // Sequencer: IDLE -> ISSUE -> RELEASE -> IDLE. RELEASE is a mandatory
    // one-cycle gap that keeps cf_start low so the core re-arms, and it also
    // masks the just-served requester's req in its done cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_hash_out <= '0;
            r_busy     <= 1'b0;
            r_cf_start <= 1'b0;
            r_cf_iv    <= '0;
            r_cf_blk   <= '0;
`ifdef SM3_CF_ARB_WDOG_EN
            r_err      <= '0;
            r_wdog_cnt <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_cf_iv    <= bus.req_iv[256*w_win_idx +: 256];
                        r_cf_blk   <= bus.req_blk[512*w_win_idx +: 512];
                        r_idx      <= w_win_idx;
                        r_gnt      <= c_ONE << w_win_idx;
                        r_cf_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_ptr      <= w_ptr_next;
                        r_state    <= c_ISSUE;
`ifdef SM3_CF_ARB_WDOG_EN
                        r_wdog_cnt <= '0;
`endif
                    end
                end

                c_ISSUE: begin
                    // cf_end takes priority over a coincident timeout.
                    if (bus.cf_end) begin
                        r_hash_out <= bus.cf_hash;
                        r_done     <= c_ONE << r_idx;
                        r_cf_start <= 1'b0;
                        r_gnt      <= '0;
                        r_state    <= c_RELEASE;
                    end
`ifdef SM3_CF_ARB_WDOG_EN
                    else if (r_wdog_cnt == c_WDOG_LAST) begin
                        // This cycle brings the count to WDOG_CYCLES: abort.
                        r_wdog_cnt <= r_wdog_cnt + c_WDOG_W'(1);
                        r_err      <= c_ONE << r_idx;
                        r_cf_start <= 1'b0;
                        r_gnt      <= '0;
                        r_state    <= c_RELEASE;
                    end else begin
                        r_wdog_cnt <= r_wdog_cnt + c_WDOG_W'(1);
                    end
`endif
                end

                c_RELEASE: begin
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
`ifdef SM3_CF_ARB_WDOG_EN
                    r_err   <= '0;
`endif
                end

                default: begin
                    r_gnt      <= '0;
                    r_done     <= '0;
                    r_cf_start <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= c_IDLE;
`ifdef SM3_CF_ARB_WDOG_EN
                    r_err      <= '0;
`endif
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.done     = r_done;
    assign bus.hash_out = r_hash_out;
    assign bus.busy     = r_busy;
    assign bus.cf_start = r_cf_start;
    assign bus.cf_iv    = r_cf_iv;
    assign bus.cf_blk   = r_cf_blk;
`ifdef SM3_CF_ARB_WDOG_EN
    assign bus.err      = r_err;
`else
    assign bus.err      = '0;
`endif

endmodule
`default_nettype wire
